// File: rtl/tl_ul_mon_pkg.sv
// ---------------------------------------------------------------------------
// tl_ul_mon_pkg
// Shared definitions for the TileLink-UL inflight monitor:
//   - A/D channel opcode constants
//   - err_code_e : violation codes 0..7, also the bit positions in err_sticky
//   - expected_mask() : the byte-lane group an access of a given size/address
//     must drive, for a bus of a given width
// ---------------------------------------------------------------------------
package tl_ul_mon_pkg;

  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_GET             = 3'd4;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  // Widest beat (in byte lanes) expected_mask() can describe.
  localparam int MAX_LANES = 64;
  localparam int NUM_ERRS  = 8;

  typedef enum logic [3:0] {
    ERR_A_OPCODE     = 4'd0,
    ERR_A_PARAM      = 4'd1,
    ERR_A_ALIGN      = 4'd2,
    ERR_A_MASK       = 4'd3,
    ERR_A_DUP_SOURCE = 4'd4,
    ERR_D_UNEXPECTED = 4'd5,
    ERR_D_MISMATCH   = 4'd6,
    ERR_TIMEOUT      = 4'd7
  } err_code_e;

  // Lanes covered by an access: the whole beat when the access is at least
  // one beat wide, otherwise the size-aligned group of 2**size lanes that
  // contains the addressed byte. Bits at and above 'lanes' are always zero.
  function automatic logic [MAX_LANES-1:0] expected_mask(
    input int unsigned lanes,
    input int unsigned lanes_log2,
    input int unsigned size,
    input int unsigned addr
  );
    logic [MAX_LANES-1:0] m;
    int unsigned group;
    int unsigned base;
    m = '0;
    if (size >= lanes_log2) begin
      group = lanes;
      base  = 0;
    end else begin
      group = 32'd1 << size;
      base  = addr & (lanes - 1) & ~(group - 1);
    end
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      m[i] = (i >= base) && (i < base + group) && (i < lanes);
    end
    return m;
  endfunction

endpackage

// File: rtl/tl_ul_source_table.sv
// ---------------------------------------------------------------------------
// tl_ul_source_table
// One entry per source ID: valid, expected D opcode, request size.
// Ports:
//   clock, reset               : clock, synchronous active-high reset (clears valid)
//   alloc_en/source/exp_opcode/size : write an entry (marks it valid)
//   retire_en/source           : clear an entry's valid bit
//   a_lookup_source -> a_lookup_valid
//   d_lookup_source -> d_lookup_valid/exp_opcode/size
// Lookups return the contents as they were at the start of the cycle, so a
// same-cycle alloc/retire never influences the checks made in that cycle.
// When alloc and retire hit the same entry in one cycle, alloc wins.
// ---------------------------------------------------------------------------
module tl_ul_source_table
  import tl_ul_mon_pkg::*;
#(
  parameter int SOURCE_BITS = 5,
  parameter int SIZE_BITS   = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   alloc_en,
  input  logic [SOURCE_BITS-1:0] alloc_source,
  input  logic                   alloc_exp_opcode,
  input  logic [SIZE_BITS-1:0]   alloc_size,
  input  logic                   retire_en,
  input  logic [SOURCE_BITS-1:0] retire_source,
  input  logic [SOURCE_BITS-1:0] a_lookup_source,
  output logic                   a_lookup_valid,
  input  logic [SOURCE_BITS-1:0] d_lookup_source,
  output logic                   d_lookup_valid,
  output logic                   d_lookup_exp_opcode,
  output logic [SIZE_BITS-1:0]   d_lookup_size
);

  localparam int DEPTH = 1 << SOURCE_BITS;

  logic [DEPTH-1:0]     valid_reg;
  logic [DEPTH-1:0]     valid_next;
  logic                 exp_opcode_mem [DEPTH];
  logic [SIZE_BITS-1:0] size_mem       [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_next[gi] =
        (alloc_en && alloc_source == SOURCE_BITS'(gi)) ? 1'b1 :
        (retire_en && retire_source == SOURCE_BITS'(gi)) ? 1'b0 :
        valid_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Payload needs no reset: it is only ever looked at behind a valid bit.
  // Reads are asynchronous because the checks need this cycle's contents.
  always_ff @(posedge clock) begin
    if (alloc_en) begin
      exp_opcode_mem[alloc_source] <= alloc_exp_opcode;
      size_mem[alloc_source]       <= alloc_size;
    end
  end

  assign a_lookup_valid      = valid_reg[a_lookup_source];
  assign d_lookup_valid      = valid_reg[d_lookup_source];
  assign d_lookup_exp_opcode = exp_opcode_mem[d_lookup_source];
  assign d_lookup_size       = size_mem[d_lookup_source];

endmodule

// File: rtl/tl_ul_inflight_monitor.sv
// ---------------------------------------------------------------------------
// tl_ul_inflight_monitor
// Passive TileLink-UL monitor on one A/D channel pair. Tracks outstanding
// requests per source, checks A legality and D correspondence, and runs a
// no-progress watchdog.
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   a_* / d_*           : observed A and D channels (fire = valid & ready)
//   clear_sticky        : clears err_sticky (new violations in the same cycle win)
//   err_pulse           : one-cycle pulse, the cycle after a violating cycle
//   err_code/err_source : lowest-numbered violation and its source; held
//   err_sticky          : OR of all violation bits since reset/clear
//   inflight_cnt        : number of valid table entries
// ---------------------------------------------------------------------------
module tl_ul_inflight_monitor
  import tl_ul_mon_pkg::*;
#(
  parameter int SOURCE_BITS = 5,
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BYTES  = 4,
  parameter int SIZE_BITS   = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_param,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic [DATA_BYTES-1:0]  a_mask,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [1:0]             d_param,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   d_denied,
  input  logic                   d_corrupt,
  input  logic                   clear_sticky,
  output logic                   err_pulse,
  output logic [3:0]             err_code,
  output logic [SOURCE_BITS-1:0] err_source,
  output logic [7:0]             err_sticky,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int LANE_BITS = $clog2(DATA_BYTES);
  localparam int CNT_BITS  = SOURCE_BITS + 1;
  localparam int WD_BITS   = $clog2(TIMEOUT);
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT - 1);

  logic a_fire, d_fire;
  assign a_fire = a_valid && a_ready;
  assign d_fire = d_valid && d_ready;

  // Denied/corrupt are informational only for this monitor.
  logic unused_d_flags;
  assign unused_d_flags = d_denied ^ d_corrupt;

  // ---- source table -------------------------------------------------------
  logic                 a_entry_valid;
  logic                 d_entry_valid;
  logic                 d_entry_exp_opcode;
  logic [SIZE_BITS-1:0] d_entry_size;
  logic                 d_retire;
  logic                 a_dup;
  logic                 a_alloc_new;

  assign d_retire = d_fire && d_entry_valid;
  // An entry being retired by D this cycle may be reused by A this cycle.
  assign a_dup = a_entry_valid && !(d_retire && d_source == a_source);
  // Only a previously-free entry grows the count; a dup just overwrites.
  assign a_alloc_new = a_fire && !a_dup;

  tl_ul_source_table #(
    .SOURCE_BITS (SOURCE_BITS),
    .SIZE_BITS   (SIZE_BITS)
  ) u_table (
    .clock               (clock),
    .reset               (reset),
    .alloc_en            (a_fire),
    .alloc_source        (a_source),
    .alloc_exp_opcode    (a_opcode == A_GET),
    .alloc_size          (a_size),
    .retire_en           (d_retire),
    .retire_source       (d_source),
    .a_lookup_source     (a_source),
    .a_lookup_valid      (a_entry_valid),
    .d_lookup_source     (d_source),
    .d_lookup_valid      (d_entry_valid),
    .d_lookup_exp_opcode (d_entry_exp_opcode),
    .d_lookup_size       (d_entry_size)
  );

  // ---- A-channel legality -------------------------------------------------
  logic [ADDR_BITS-1:0] align_sel;
  generate
    for (genvar gi = 0; gi < ADDR_BITS; gi++) begin : g_align
      assign align_sel[gi] = int'(a_size) > gi;
    end
  endgenerate

  logic a_opcode_bad;
  logic a_misaligned;
  logic a_mask_bad;
  logic mask_full;
  logic [MAX_LANES-1:0] exp_mask_wide;
  logic [MAX_LANES-1:0] a_mask_wide;

  assign a_opcode_bad = !(a_opcode == A_GET || a_opcode == A_PUT_FULL ||
                          a_opcode == A_PUT_PARTIAL);
  assign a_misaligned = |(a_address & align_sel);
  assign mask_full    = int'(a_size) >= LANE_BITS;
  assign a_mask_wide  = MAX_LANES'(a_mask);
  assign exp_mask_wide = expected_mask(DATA_BYTES, LANE_BITS, 32'(a_size), 32'(a_address));

  // Sub-beat PutPartial may drive any nonzero subset of its lane group;
  // everything else must drive exactly the group (the full beat when wide).
  assign a_mask_bad = (a_opcode == A_PUT_PARTIAL && !mask_full) ?
                      (a_mask_wide == '0 || (a_mask_wide & ~exp_mask_wide) != '0) :
                      (a_mask_wide != exp_mask_wide);

  // ---- watchdog and inflight count ----------------------------------------
  logic [WD_BITS-1:0]  wd_reg;
  logic [CNT_BITS-1:0] inflight_reg;
  logic                wd_timeout;

  assign wd_timeout = !d_fire && inflight_reg != '0 && wd_reg == WD_LAST;

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_reg       <= '0;
      inflight_reg <= '0;
    end else begin
      if (d_fire || inflight_reg == '0 || wd_timeout) begin
        wd_reg <= '0;
      end else begin
        wd_reg <= wd_reg + 1'b1;
      end
      inflight_reg <= inflight_reg + CNT_BITS'(a_alloc_new) - CNT_BITS'(d_retire);
    end
  end

  // ---- violation collection -----------------------------------------------
  logic [NUM_ERRS-1:0] err_vec;
  always_comb begin
    err_vec                   = '0;
    err_vec[ERR_A_OPCODE]     = a_fire && a_opcode_bad;
    err_vec[ERR_A_PARAM]      = a_fire && a_param != 3'd0;
    err_vec[ERR_A_ALIGN]      = a_fire && a_misaligned;
    err_vec[ERR_A_MASK]       = a_fire && a_mask_bad;
    err_vec[ERR_A_DUP_SOURCE] = a_fire && a_dup;
    err_vec[ERR_D_UNEXPECTED] = d_fire && !d_entry_valid;
    err_vec[ERR_D_MISMATCH]   = d_fire &&
      ((d_entry_valid && (d_opcode != {2'b00, d_entry_exp_opcode} ||
                          d_size != d_entry_size)) ||
       d_param != 2'd0);
    err_vec[ERR_TIMEOUT]      = wd_timeout;
  end

  logic [3:0]             lowest_code;
  logic [SOURCE_BITS-1:0] lowest_source;
  always_comb begin
    lowest_code = 4'd0;
    for (int i = NUM_ERRS - 1; i >= 0; i--) begin
      if (err_vec[i]) lowest_code = 4'(i);
    end
    if (lowest_code <= ERR_A_DUP_SOURCE) begin
      lowest_source = a_source;
    end else if (lowest_code <= ERR_D_MISMATCH) begin
      lowest_source = d_source;
    end else begin
      lowest_source = '0;
    end
  end

  logic                   err_pulse_reg;
  logic [3:0]             err_code_reg;
  logic [SOURCE_BITS-1:0] err_source_reg;
  logic [7:0]             err_sticky_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_pulse_reg  <= 1'b0;
      err_code_reg   <= 4'd0;
      err_source_reg <= '0;
      err_sticky_reg <= 8'd0;
    end else begin
      err_pulse_reg <= |err_vec;
      if (|err_vec) begin
        err_code_reg   <= lowest_code;
        err_source_reg <= lowest_source;
      end
      // OR after the clear so a violation in the clearing cycle survives.
      err_sticky_reg <= (clear_sticky ? 8'd0 : err_sticky_reg) | err_vec;
    end
  end

  assign err_pulse    = err_pulse_reg;
  assign err_code     = err_code_reg;
  assign err_source   = err_source_reg;
  assign err_sticky   = err_sticky_reg;
  assign inflight_cnt = inflight_reg;

endmodule

// File: tb/tb_tl_ul_inflight_monitor.sv
// ---------------------------------------------------------------------------
// tb_tl_ul_inflight_monitor
// Directed stimulus with hand-computed expectations for the inflight
// monitor, built with a short watchdog (TIMEOUT=16).
// ---------------------------------------------------------------------------
module tb_tl_ul_inflight_monitor;

  localparam int SB = 5;
  localparam int AB = 32;
  localparam int DB = 4;
  localparam int ZB = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_valid, a_ready;
  logic [2:0]    a_opcode, a_param;
  logic [ZB-1:0] a_size;
  logic [SB-1:0] a_source;
  logic [AB-1:0] a_address;
  logic [DB-1:0] a_mask;
  logic          d_valid, d_ready;
  logic [2:0]    d_opcode;
  logic [1:0]    d_param;
  logic [ZB-1:0] d_size;
  logic [SB-1:0] d_source;
  logic          d_denied, d_corrupt;
  logic          clear_sticky;
  logic          err_pulse;
  logic [3:0]    err_code;
  logic [SB-1:0] err_source;
  logic [7:0]    err_sticky;
  logic [SB:0]   inflight_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clock = ~clock;

  tl_ul_inflight_monitor #(
    .SOURCE_BITS (SB),
    .ADDR_BITS   (AB),
    .DATA_BYTES  (DB),
    .SIZE_BITS   (ZB),
    .TIMEOUT     (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_opcode     (a_opcode),
    .a_param      (a_param),
    .a_size       (a_size),
    .a_source     (a_source),
    .a_address    (a_address),
    .a_mask       (a_mask),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_opcode     (d_opcode),
    .d_param      (d_param),
    .d_size       (d_size),
    .d_source     (d_source),
    .d_denied     (d_denied),
    .d_corrupt    (d_corrupt),
    .clear_sticky (clear_sticky),
    .err_pulse    (err_pulse),
    .err_code     (err_code),
    .err_source   (err_source),
    .err_sticky   (err_sticky),
    .inflight_cnt (inflight_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
      $display("ok   %s: 0x%0h", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable when this returns.
  task automatic step();
    @(posedge clock);
    #1;
    a_valid      = 1'b0;
    d_valid      = 1'b0;
    clear_sticky = 1'b0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [ZB-1:0] size,
                         input logic [SB-1:0] src, input logic [AB-1:0] addr,
                         input logic [DB-1:0] mask);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_param   = 3'd0;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [ZB-1:0] size,
                         input logic [SB-1:0] src);
    d_valid  = 1'b1;
    d_opcode = op;
    d_param  = 2'd0;
    d_size   = size;
    d_source = src;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; a_valid = 1'b0; a_ready = 1'b1; a_opcode = '0; a_param = '0;
    a_size = '0; a_source = '0; a_address = '0; a_mask = '0;
    d_valid = 1'b0; d_ready = 1'b1; d_opcode = '0; d_param = '0; d_size = '0;
    d_source = '0; d_denied = 1'b0; d_corrupt = 1'b0; clear_sticky = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check_eq("rst_pulse", 32'(err_pulse), 32'd0);
    check_eq("rst_code", 32'(err_code), 32'd0);
    check_eq("rst_source", 32'(err_source), 32'd0);
    check_eq("rst_sticky", 32'(err_sticky), 32'd0);
    check_eq("rst_inflight", 32'(inflight_cnt), 32'd0);

    // Legal Get / AccessAckData pair
    drive_a(3'd4, 3'd2, 5'd3, 32'h100, 4'hF); step();
    check_eq("get_pulse", 32'(err_pulse), 32'd0);
    check_eq("get_inflight", 32'(inflight_cnt), 32'd1);
    drive_d(3'd1, 3'd2, 5'd3); step();
    check_eq("ack_pulse", 32'(err_pulse), 32'd0);
    check_eq("ack_inflight", 32'(inflight_cnt), 32'd0);
    check_eq("ack_sticky", 32'(err_sticky), 32'd0);

    // Duplicate source
    drive_a(3'd4, 3'd2, 5'd5, 32'h40, 4'hF); step();
    check_eq("dup1_pulse", 32'(err_pulse), 32'd0);
    drive_a(3'd4, 3'd2, 5'd5, 32'h40, 4'hF); step();
    check_eq("dup_pulse", 32'(err_pulse), 32'd1);
    check_eq("dup_code", 32'(err_code), 32'd4);
    check_eq("dup_source", 32'(err_source), 32'd5);
    check_eq("dup_sticky", 32'(err_sticky), 32'h10);
    check_eq("dup_inflight", 32'(inflight_cnt), 32'd1);
    step();
    check_eq("hold_pulse", 32'(err_pulse), 32'd0);
    check_eq("hold_code", 32'(err_code), 32'd4);
    check_eq("hold_source", 32'(err_source), 32'd5);
    do_reset();

    // Unexpected D, sticky clear, clear racing a new violation
    drive_d(3'd0, 3'd2, 5'd7); step();
    check_eq("unexp_pulse", 32'(err_pulse), 32'd1);
    check_eq("unexp_code", 32'(err_code), 32'd5);
    check_eq("unexp_source", 32'(err_source), 32'd7);
    check_eq("unexp_sticky", 32'(err_sticky), 32'h20);
    check_eq("unexp_inflight", 32'(inflight_cnt), 32'd0);
    clear_sticky = 1'b1; step();
    check_eq("clr_sticky", 32'(err_sticky), 32'd0);
    check_eq("clr_pulse", 32'(err_pulse), 32'd0);
    clear_sticky = 1'b1; drive_d(3'd0, 3'd2, 5'd7); step();
    check_eq("clr_race_sticky", 32'(err_sticky), 32'h20);
    check_eq("clr_race_pulse", 32'(err_pulse), 32'd1);
    do_reset();

    // Mismatch, misalignment, mask errors, legal PutPartial
    drive_a(3'd0, 3'd2, 5'd1, 32'h0, 4'hF); step();
    check_eq("putfull_pulse", 32'(err_pulse), 32'd0);
    drive_d(3'd1, 3'd2, 5'd1); step();
    check_eq("mism_pulse", 32'(err_pulse), 32'd1);
    check_eq("mism_code", 32'(err_code), 32'd6);
    check_eq("mism_source", 32'(err_source), 32'd1);
    check_eq("mism_inflight", 32'(inflight_cnt), 32'd0);
    drive_a(3'd4, 3'd2, 5'd8, 32'h102, 4'hF); step();
    check_eq("align_code", 32'(err_code), 32'd2);
    check_eq("align_source", 32'(err_source), 32'd8);
    drive_a(3'd4, 3'd0, 5'd9, 32'h1, 4'h1); step();
    check_eq("mask_pulse", 32'(err_pulse), 32'd1);
    check_eq("mask_code", 32'(err_code), 32'd3);
    check_eq("mask_source", 32'(err_source), 32'd9);
    drive_a(3'd1, 3'd1, 5'd10, 32'h2, 4'h4); step();
    check_eq("partial_pulse", 32'(err_pulse), 32'd0);
    check_eq("partial_inflight", 32'(inflight_cnt), 32'd3);
    check_eq("partial_sticky", 32'(err_sticky), 32'h4C);
    do_reset();

    // Same-cycle retire and reallocate of one source
    drive_a(3'd4, 3'd2, 5'd2, 32'h0, 4'hF); step();
    check_eq("reuse_first_inflight", 32'(inflight_cnt), 32'd1);
    drive_a(3'd4, 3'd2, 5'd2, 32'h0, 4'hF); drive_d(3'd1, 3'd2, 5'd2); step();
    check_eq("reuse_pulse", 32'(err_pulse), 32'd0);
    check_eq("reuse_inflight", 32'(inflight_cnt), 32'd1);
    check_eq("reuse_sticky", 32'(err_sticky), 32'd0);
    do_reset();

    // Watchdog: first error 16 cycles after the fire edge, then every 16
    drive_a(3'd4, 3'd2, 5'd4, 32'h0, 4'hF); step();
    check_eq("wd_fire_pulse", 32'(err_pulse), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step();
      check_eq($sformatf("wd_quiet1_%0d", i), 32'(err_pulse), 32'd0);
    end
    step();
    check_eq("wd1_pulse", 32'(err_pulse), 32'd1);
    check_eq("wd1_code", 32'(err_code), 32'd7);
    check_eq("wd1_source", 32'(err_source), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step();
      check_eq($sformatf("wd_quiet2_%0d", i), 32'(err_pulse), 32'd0);
    end
    step();
    check_eq("wd2_pulse", 32'(err_pulse), 32'd1);
    check_eq("wd2_code", 32'(err_code), 32'd7);
    check_eq("wd2_sticky", 32'(err_sticky), 32'h80);

    // Reset discards the outstanding Get; a late response is unexpected
    do_reset();
    check_eq("mid_rst_pulse", 32'(err_pulse), 32'd0);
    check_eq("mid_rst_code", 32'(err_code), 32'd0);
    check_eq("mid_rst_sticky", 32'(err_sticky), 32'd0);
    check_eq("mid_rst_inflight", 32'(inflight_cnt), 32'd0);
    drive_d(3'd1, 3'd2, 5'd4); step();
    check_eq("late_pulse", 32'(err_pulse), 32'd1);
    check_eq("late_code", 32'(err_code), 32'd5);
    check_eq("late_source", 32'(err_source), 32'd4);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
